// File: rtl/gpi_pad_ctrl.sv
// rtl/gpi_pad_ctrl.sv - GPI pad bank controller: IE/STE config, settle sequencing, debounce, edge interrupts
module gpi_pad_ctrl #(
    parameter int N_PADS     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PRESC      = 16,
    parameter int DB_TICKS   = 4,
    parameter int SETTLE_CYC = 8,
    localparam int AW        = (N_PADS > 1) ? $clog2(N_PADS) : 1
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  CFG_WE_I,
    input  logic [AW-1:0]         CFG_ADDR_I,
    input  logic [3:0]            CFG_WDATA_I,
    output logic [3:0]            CFG_RDATA_O,
    input  logic                  CLR_WE_I,
    input  logic [N_PADS-1:0]     CLR_MASK_I,
    output logic [N_PADS-1:0]     IE_O,
    output logic [2*N_PADS-1:0]   STE_O,
    input  logic [2*N_PADS-1:0]   DI_I,
    output logic [N_PADS-1:0]     ACTIVE_O,
    output logic [N_PADS-1:0]     LEVEL_O,
    output logic [N_PADS-1:0]     RISE_PEND_O,
    output logic [N_PADS-1:0]     FALL_PEND_O,
    output logic                  IRQ_O
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [AW:0]   NP_W      = N_PADS[AW:0];
    localparam logic [PW-1:0] PRESC_TOP = PW'(PRESC - 1);
    localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYC - 1);
    localparam logic [3:0]    DB_LAST   = 4'(DB_TICKS - 1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACTIVE = 2'd2
    } pad_state_e;

    pad_state_e             state_q  [N_PADS];
    pad_state_e             state_d  [N_PADS];
    logic [3:0]             cfg_q    [N_PADS];
    logic [SYNC_STAGES-1:0] sync_q   [N_PADS];
    logic [3:0]             stab_q   [N_PADS];
    logic [3:0]             stab_d   [N_PADS];
    logic [SW-1:0]          settle_q [N_PADS];
    logic [SW-1:0]          settle_d [N_PADS];

    logic [PW-1:0]     presc_q;
    logic              tick;
    logic              addr_ok;
    logic              cfg_hit;
    logic [N_PADS-1:0] ie_nxt;
    logic [N_PADS-1:0] irq_en;
    logic [N_PADS-1:0] sync_val;
    logic [N_PADS-1:0] level_q;
    logic [N_PADS-1:0] level_d;
    logic [N_PADS-1:0] rise_q;
    logic [N_PADS-1:0] fall_q;
    logic [N_PADS-1:0] rise_set;
    logic [N_PADS-1:0] fall_set;
    logic [N_PADS-1:0] clr_vec;
    logic [N_PADS-1:0] active;
    logic [N_PADS-1:0] di_odd_unused;
    logic              irq_q;

    assign tick    = (presc_q == PRESC_TOP);
    assign addr_ok = ({1'b0, CFG_ADDR_I} < NP_W);
    assign cfg_hit = CFG_WE_I && addr_ok;
    assign clr_vec = CLR_WE_I ? CLR_MASK_I : '0;

    assign CFG_RDATA_O = addr_ok ? cfg_q[CFG_ADDR_I] : 4'h0;
    assign ACTIVE_O    = active;
    assign LEVEL_O     = level_q;
    assign RISE_PEND_O = rise_q;
    assign FALL_PEND_O = fall_q;
    assign IRQ_O       = irq_q;

    // The FSM steers from the ie value being written this cycle, so IE_O and the state move together.
    always_comb begin
        ie_nxt        = '0;
        irq_en        = '0;
        sync_val      = '0;
        di_odd_unused = '0;
        STE_O         = '0;
        IE_O          = '0;
        for (int p = 0; p < N_PADS; p++) begin
            ie_nxt[p] = cfg_q[p][0];
            if (cfg_hit && (CFG_ADDR_I == AW'(p))) begin
                ie_nxt[p] = CFG_WDATA_I[0];
            end
            IE_O[p]          = cfg_q[p][0];
            irq_en[p]        = cfg_q[p][3];
            STE_O[2*p +: 2]  = cfg_q[p][2:1];
            sync_val[p]      = sync_q[p][SYNC_STAGES-1];
            di_odd_unused[p] = DI_I[2*p+1];
        end
    end

    always_ff @(posedge CLK_I) begin
        for (int p = 0; p < N_PADS; p++) begin
            if (RST_I) begin
                state_q[p] <= ST_OFF;
            end else begin
                state_q[p] <= state_d[p];
            end
        end
    end

    always_comb begin
        for (int p = 0; p < N_PADS; p++) begin
            state_d[p] = state_q[p];
            case (state_q[p])
                ST_OFF: begin
                    if (ie_nxt[p]) state_d[p] = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (!ie_nxt[p])             state_d[p] = ST_OFF;
                    else if (settle_q[p] == '0) state_d[p] = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (!ie_nxt[p]) state_d[p] = ST_OFF;
                end
                default: state_d[p] = ST_OFF;
            endcase
        end
    end

    always_comb begin
        active = '0;
        for (int p = 0; p < N_PADS; p++) begin
            active[p] = (state_q[p] == ST_ACTIVE);
        end
    end

    always_comb begin
        level_d  = level_q;
        rise_set = '0;
        fall_set = '0;
        for (int p = 0; p < N_PADS; p++) begin
            stab_d[p]   = stab_q[p];
            settle_d[p] = settle_q[p];

            if (state_q[p] == ST_OFF && state_d[p] == ST_SETTLE) begin
                settle_d[p] = SETTLE_LD;
            end else if (state_q[p] == ST_SETTLE && settle_q[p] != '0) begin
                settle_d[p] = settle_q[p] - 1'b1;
            end

            if (state_d[p] == ST_OFF) begin
                level_d[p] = 1'b0;
                stab_d[p]  = '0;
            end else if (state_q[p] == ST_SETTLE) begin
                // Entering ACTIVE adopts the current level silently as the debounce reference.
                stab_d[p] = '0;
                if (state_d[p] == ST_ACTIVE) level_d[p] = sync_val[p];
            end else if (state_q[p] == ST_ACTIVE) begin
                if (sync_val[p] == level_q[p]) begin
                    stab_d[p] = '0;
                end else if (tick) begin
                    if (stab_q[p] == DB_LAST) begin
                        level_d[p]  = sync_val[p];
                        stab_d[p]   = '0;
                        rise_set[p] = sync_val[p];
                        fall_set[p] = ~sync_val[p];
                    end else begin
                        stab_d[p] = stab_q[p] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            presc_q <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            irq_q   <= 1'b0;
            for (int p = 0; p < N_PADS; p++) begin
                cfg_q[p]    <= '0;
                sync_q[p]   <= '0;
                stab_q[p]   <= '0;
                settle_q[p] <= '0;
            end
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (cfg_hit) cfg_q[CFG_ADDR_I] <= CFG_WDATA_I;
            level_q <= level_d;
            // A new edge outranks a clear landing in the same cycle.
            rise_q  <= (rise_q & ~clr_vec) | rise_set;
            fall_q  <= (fall_q & ~clr_vec) | fall_set;
            irq_q   <= |((rise_q | fall_q) & irq_en);
            for (int p = 0; p < N_PADS; p++) begin
                sync_q[p]   <= {sync_q[p][SYNC_STAGES-2:0], DI_I[2*p]};
                stab_q[p]   <= stab_d[p];
                settle_q[p] <= settle_d[p];
            end
        end
    end

endmodule

// File: tb/tb_gpi_pad_ctrl.sv
// tb/tb_gpi_pad_ctrl.sv - randomized scoreboard bench for gpi_pad_ctrl
module tb_gpi_pad_ctrl;

    localparam int N     = 8;
    localparam int S     = 2;
    localparam int PRESC = 16;
    localparam int DBT   = 4;
    localparam int SET   = 8;
    localparam int AW    = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_we;
    logic [AW-1:0]  cfg_addr;
    logic [3:0]     cfg_wdata;
    logic [3:0]     cfg_rdata;
    logic           clr_we;
    logic [N-1:0]   clr_mask;
    logic [N-1:0]   ie, active, level, rise, fall;
    logic [2*N-1:0] ste, di;
    logic           irq;

    always #5 clk = ~clk;

    gpi_pad_ctrl #(
        .N_PADS(N), .SYNC_STAGES(S), .PRESC(PRESC), .DB_TICKS(DBT), .SETTLE_CYC(SET)
    ) dut (
        .CLK_I(clk), .RST_I(rst),
        .CFG_WE_I(cfg_we), .CFG_ADDR_I(cfg_addr), .CFG_WDATA_I(cfg_wdata), .CFG_RDATA_O(cfg_rdata),
        .CLR_WE_I(clr_we), .CLR_MASK_I(clr_mask),
        .IE_O(ie), .STE_O(ste), .DI_I(di),
        .ACTIVE_O(active), .LEVEL_O(level), .RISE_PEND_O(rise), .FALL_PEND_O(fall), .IRQ_O(irq)
    );

    typedef struct packed {
        logic [3:0]     rdata;
        logic [N-1:0]   ie;
        logic [2*N-1:0] ste;
        logic [N-1:0]   active;
        logic [N-1:0]   level;
        logic [N-1:0]   rise;
        logic [N-1:0]   fall;
        logic           irq;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: pad mode 0=off 1=settling 2=active, plus counts of remaining settle cycles and unstable ticks.
    logic [3:0]     m_cfg [N];
    int             m_mode [N];
    int             m_left [N];
    int             m_unst [N];
    bit             m_lvl [N];
    bit             m_rise [N];
    bit             m_fall [N];
    bit             m_irq;
    int             m_cycles;
    logic [2*N-1:0] di_log[$];

    task automatic model_edge();
        logic [2*N-1:0] seen;
        logic [3:0]     nc [N];
        bit             tick, irq_new, s;
        if (rst) begin
            for (int p = 0; p < N; p++) begin
                m_cfg[p] = '0; m_mode[p] = 0; m_left[p] = 0; m_unst[p] = 0;
                m_lvl[p] = 0; m_rise[p] = 0; m_fall[p] = 0;
            end
            m_irq = 0;
            m_cycles = 0;
            di_log.delete();
            repeat (S) di_log.push_back('0);
            return;
        end
        tick = ((m_cycles % PRESC) == PRESC - 1);
        m_cycles++;
        seen = di_log.pop_front();
        di_log.push_back(di);
        irq_new = 0;
        for (int p = 0; p < N; p++) begin
            if ((m_rise[p] || m_fall[p]) && m_cfg[p][3]) irq_new = 1;
            nc[p] = m_cfg[p];
        end
        if (cfg_we && int'(cfg_addr) < N) nc[cfg_addr] = cfg_wdata;
        for (int p = 0; p < N; p++) begin
            bit rs, fs;
            rs = 0; fs = 0;
            s = seen[2*p];
            if (!nc[p][0]) begin
                m_mode[p] = 0; m_lvl[p] = 0; m_unst[p] = 0;
            end else if (m_mode[p] == 0) begin
                m_mode[p] = 1; m_left[p] = SET - 1;
            end else if (m_mode[p] == 1) begin
                if (m_left[p] == 0) begin
                    m_mode[p] = 2; m_lvl[p] = s; m_unst[p] = 0;
                end else begin
                    m_left[p]--;
                end
            end else begin
                if (s == m_lvl[p]) m_unst[p] = 0;
                else if (tick) begin
                    m_unst[p]++;
                    if (m_unst[p] == DBT) begin
                        m_lvl[p] = s; m_unst[p] = 0; rs = s; fs = !s;
                    end
                end
            end
            if (clr_we && clr_mask[p]) begin
                m_rise[p] = 0; m_fall[p] = 0;
            end
            if (rs) m_rise[p] = 1;
            if (fs) m_fall[p] = 1;
        end
        for (int p = 0; p < N; p++) m_cfg[p] = nc[p];
        m_irq = irq_new;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e = '0;
        e.rdata = (int'(cfg_addr) < N) ? m_cfg[cfg_addr] : 4'h0;
        for (int p = 0; p < N; p++) begin
            e.ie[p]         = m_cfg[p][0];
            e.ste[2*p +: 2] = m_cfg[p][2:1];
            e.active[p]     = (m_mode[p] == 2);
            e.level[p]      = m_lvl[p];
            e.rise[p]       = m_rise[p];
            e.fall[p]       = m_fall[p];
        end
        e.irq = m_irq;
        return e;
    endfunction

    task automatic drive(input bit r, input bit we, input logic [AW-1:0] a, input logic [3:0] wd,
                         input bit cw, input logic [N-1:0] cm);
        rst = r; cfg_we = we; cfg_addr = a; cfg_wdata = wd; clr_we = cw; clr_mask = cm;
        model_edge();
        exp_q.push_back(model_out());
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, AW'($urandom), 4'h0, 0, '0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cfg_rdata", 32'(cfg_rdata), 32'(e.rdata));
                chk("ie",        32'(ie),        32'(e.ie));
                chk("ste",       32'(ste),       32'(e.ste));
                chk("active",    32'(active),    32'(e.active));
                chk("level",     32'(level),     32'(e.level));
                chk("rise_pend", 32'(rise),      32'(e.rise));
                chk("fall_pend", 32'(fall),      32'(e.fall));
                chk("irq",       32'(irq),       32'(e.irq));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int wait_cyc;
        rst = 1; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0; clr_we = 0; clr_mask = '0;
        di = {2*N{1'b1}};
        @(negedge clk);
        #1;
        repeat (3) drive(1, 0, 3'd5, 4'h0, 0, '0);

        drive(0, 1, 3'd3, 4'h3, 0, '0);
        idle(12);
        for (int p = 0; p < N; p++) drive(0, 1, AW'(p), 4'b1001, 0, '0);
        idle(20);
        di[0] = 1'b0;
        idle(100);
        di[0] = 1'b1;
        idle(100);
        di[0] = 1'b0;
        idle(48);
        di[0] = 1'b1;
        idle(60);
        di[0] = 1'b0;
        idle(100);
        di[0] = 1'b1;
        idle(64);
        while (!(rise[0])) begin
            if (level[0]) break;
            drive(0, 0, 3'd0, 4'h0, 1, 8'h01);
        end
        idle(20);
        drive(0, 1, 3'd2, 4'h0, 0, '0);
        drive(0, 1, 3'd2, 4'h1, 0, '0);
        idle(3);
        drive(0, 1, 3'd2, 4'h0, 0, '0);
        drive(0, 1, 3'd2, 4'h1, 0, '0);
        idle(20);
        drive(0, 1, 3'd2, 4'h0, 0, '0);
        idle(5);

        for (int i = 0; i < 15000; i++) begin
            logic [3:0] wd;
            bit         r, we, cw;
            r  = ($urandom_range(3999) == 0);
            we = ($urandom_range(39) == 0);
            cw = ($urandom_range(24) == 0);
            wd = 4'($urandom);
            if ($urandom_range(3) != 0) wd[0] = 1'b1;
            for (int b = 0; b < 2*N; b++) begin
                if ($urandom_range(59) == 0) di[b] = ~di[b];
            end
            drive(r, we, AW'($urandom), wd, cw, N'($urandom));
        end

        drive(0, 1, 3'd5, 4'b1001, 1, '1);
        idle(30);
        di[10] = ~di[10];
        idle(90);
        drive(1, 0, 3'd5, 4'h0, 0, '0);
        idle(3);

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
